// File: rtl/spis_intf.sv
// Mode-0 SPI slave moving 32-bit words. The SPI pins are oversampled on clk through 2-flop synchronizers.
// Optional registered debug bus: define SPIS_DBG_EN.
module spis_intf (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        ss_n,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic [31:0] tx_rdata,
    output logic        tx_req,
    output logic [31:0] rx_wdata,
    output logic        rx_wvld,
    output logic        frame_start,
    output logic        frame_end,
    output logic        partial_err,
    output logic [13:0] word_cnt,
    output logic [31:0] dbg_bus0
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        END   = 3'd3
    } state_t;

    localparam logic [13:0] WORD_CNT_MAX = 14'h3FFF;

    logic        r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic        r_ss_s1, r_ss_s2, r_ss_d;
    logic        r_mosi_s1, r_mosi_s2;
    logic [1:0]  r_warm;
    logic        r_armed;

    state_t      r_state, w_state_nxt;
    logic        w_start, w_load, w_rise, w_fall, w_abort, w_tx_reload;
    logic        w_ss_high, w_ss_fall, w_sclk_rise, w_sclk_fall;

    logic [31:0] r_tx_shift;
    logic [30:0] r_rx_shift;
    logic [4:0]  r_bit_cnt;
    logic [13:0] r_word_cnt;
    logic [31:0] r_rx_wdata;
    logic        r_miso_oe, r_tx_req, r_rx_wvld;
    logic        r_frame_start, r_frame_end, r_partial_err;

    // NOTE: every flop is assigned with <= so all of them sample pre-edge values in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_d  <= 1'b0;
            r_ss_s1   <= 1'b1;
            r_ss_s2   <= 1'b1;
            r_ss_d    <= 1'b1;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
            r_warm    <= 2'b00;
            r_armed   <= 1'b0;
        end else begin
            r_sclk_s1 <= sclk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_d  <= r_sclk_s2;
            r_ss_s1   <= ss_n;
            r_ss_s2   <= r_ss_s1;
            r_ss_d    <= r_ss_s2;
            r_mosi_s1 <= mosi;
            r_mosi_s2 <= r_mosi_s1;
            r_warm    <= {r_warm[0], 1'b1};
            // The reset value of the ss_n chain is not a real sample. Frames may start only after a genuine high.
            if (r_warm[1] && r_ss_s2) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_ss_high   = r_ss_s2;
    assign w_ss_fall   = r_ss_d & ~r_ss_s2 & r_armed;
    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
    assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_load      = 1'b0;
        w_rise      = 1'b0;
        w_fall      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ss_fall) begin
                    w_state_nxt = LOAD;
                    w_start     = 1'b1;
                end
            end
            LOAD: begin
                if (w_ss_high) begin
                    w_state_nxt = END;
                    w_abort     = 1'b1;
                end else begin
                    w_state_nxt = SHIFT;
                    w_load      = 1'b1;
                end
            end
            SHIFT: begin
                // Deselect wins over an sclk edge seen in the same cycle.
                if (w_ss_high) begin
                    w_state_nxt = END;
                    w_abort     = 1'b1;
                end else begin
                    w_rise = w_sclk_rise;
                    w_fall = w_sclk_fall;
                end
            end
            END: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_tx_reload = w_fall && (r_bit_cnt == 5'd0) && (r_word_cnt != 14'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_shift    <= '0;
            r_rx_shift    <= '0;
            r_bit_cnt     <= '0;
            r_word_cnt    <= '0;
            r_rx_wdata    <= '0;
            r_miso_oe     <= 1'b0;
            r_tx_req      <= 1'b0;
            r_rx_wvld     <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_partial_err <= 1'b0;
        end else begin
            r_tx_req      <= 1'b0;
            r_rx_wvld     <= 1'b0;
            r_frame_start <= w_start;
            r_frame_end   <= w_abort;
            r_partial_err <= w_abort && (r_state == SHIFT) && (r_bit_cnt != 5'd0);

            if (r_state == LOAD) begin
                r_bit_cnt  <= '0;
                r_word_cnt <= '0;
                r_rx_shift <= '0;
            end

            if (w_load || w_tx_reload) begin
                r_tx_shift <= tx_rdata;
                r_tx_req   <= 1'b1;
            end else if (w_fall) begin
                r_tx_shift <= {r_tx_shift[30:0], 1'b0};
            end

            if (w_load) begin
                r_miso_oe <= 1'b1;
            end

            if (w_rise) begin
                r_rx_shift <= {r_rx_shift[29:0], r_mosi_s2};
                r_bit_cnt  <= r_bit_cnt + 5'd1;
                if (r_bit_cnt == 5'd31) begin
                    r_rx_wdata <= {r_rx_shift, r_mosi_s2};
                    r_rx_wvld  <= 1'b1;
                    if (r_word_cnt != WORD_CNT_MAX) begin
                        r_word_cnt <= r_word_cnt + 14'd1;
                    end
                end
            end

            // Leaving END drops the drive. The partial rx word is simply abandoned.
            if (r_state == END) begin
                r_tx_shift <= '0;
                r_miso_oe  <= 1'b0;
            end
        end
    end

    assign miso        = r_tx_shift[31];
    assign miso_oe     = r_miso_oe;
    assign tx_req      = r_tx_req;
    assign rx_wdata    = r_rx_wdata;
    assign rx_wvld     = r_rx_wvld;
    assign frame_start = r_frame_start;
    assign frame_end   = r_frame_end;
    assign partial_err = r_partial_err;
    assign word_cnt    = r_word_cnt;

`ifdef SPIS_DBG_EN
    logic [31:0] r_dbg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dbg <= '0;
        end else begin
            r_dbg <= {1'b0, r_state, r_word_cnt, 9'b0, r_bit_cnt};
        end
    end

    assign dbg_bus0 = r_dbg;
`else
    assign dbg_bus0 = 32'h0;
`endif

endmodule

// File: tb/tb_spis_intf.sv
// Randomized SPI-master bench for spis_intf. A transaction-level model supplies every expected
// word, bit and pulse count, and a per-cycle compare process checks the strobes.
module tb_spis_intf;

    localparam int HALF = 4;  // sclk half period in clk cycles

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk, ss_n, mosi;
    logic        miso, miso_oe;
    logic [31:0] tx_rdata;
    logic        tx_req;
    logic [31:0] rx_wdata;
    logic        rx_wvld;
    logic        frame_start, frame_end, partial_err;
    logic [13:0] word_cnt;
    logic [31:0] dbg_bus0;

    spis_intf dut (
        .clk         (clk),
        .rst         (rst),
        .sclk        (sclk),
        .ss_n        (ss_n),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .tx_rdata    (tx_rdata),
        .tx_req      (tx_req),
        .rx_wdata    (rx_wdata),
        .rx_wvld     (rx_wvld),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .partial_err (partial_err),
        .word_cnt    (word_cnt),
        .dbg_bus0    (dbg_bus0)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] tx_vals [1024];
    int          tx_idx   = 0;
    logic [31:0] mosi_buf [8];
    logic [31:0] exp_rx [$];
    logic [31:0] miso_words [$];
    logic [31:0] last_rx  = '0;
    logic        exp_partial = 1'b0;
    int          frame_words = 0;
    int          cnt_fs = 0, cnt_fe = 0, cnt_tr = 0, cnt_wv = 0, cnt_pe = 0;
    int          last_tr_delta = 0;
    int          last_pe_delta = 0;
    logic        fe_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Upstream: after every tx_req, present the next word of the list.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_req === 1'b1) begin
                tx_idx++;
                tx_rdata = tx_vals[tx_idx];
            end
        end
    end

    // Per-cycle comparison of the strobes against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                if (rx_wvld === 1'b1) begin
                    cnt_wv++;
                    check("rx_expected", 32'(exp_rx.size() != 0), 32'd1);
                    if (exp_rx.size() != 0) begin
                        frame_words++;
                        check("rx_wdata", rx_wdata, exp_rx.pop_front());
                        check("word_cnt", 32'(word_cnt), 32'(frame_words));
                    end
                end
                if (tx_req === 1'b1) cnt_tr++;
                if (frame_start === 1'b1) cnt_fs++;
                if (partial_err === 1'b1) begin
                    cnt_pe++;
                    check("partial_with_end", 32'(frame_end), 32'd1);
                end
                if (frame_end === 1'b1) begin
                    cnt_fe++;
                    check("partial_err", 32'(partial_err), 32'(exp_partial));
`ifndef SPIS_DBG_EN
                    check("dbg_bus0", dbg_bus0, 32'd0);
`endif
                end
                if (fe_prev) check("miso_oe_after_end", 32'(miso_oe), 32'd0);
                fe_prev = frame_end;
            end else begin
                fe_prev = 1'b0;
            end
        end
    end

    // Plays one frame of n_bits. With simul_end, the final rise coincides with ss_n rising and is not counted.
    task automatic run_frame(input int n_bits, input bit trailing_fall, input bit simul_end);
        int          counted, base, fs0, fe0, tr0, wv0, pe0, falls, w, i;
        logic [31:0] exp_word, got;
        counted = simul_end ? n_bits - 1 : n_bits;
        ss_n = 1'b1;
        sclk = 1'b0;
        repeat (8) @(negedge clk);
        base = tx_idx;
        fs0 = cnt_fs; fe0 = cnt_fe; tr0 = cnt_tr; wv0 = cnt_wv; pe0 = cnt_pe;
        falls = 0;
        got = '0;
        frame_words = 0;
        exp_partial = ((counted % 32) != 0);
        miso_words.delete();
        ss_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int b = 0; b < n_bits; b++) begin
            w = b / 32;
            i = 31 - (b % 32);
            exp_word = tx_vals[base + w];
            mosi = mosi_buf[w][i];
            repeat (HALF) @(negedge clk);
            if (simul_end && b == n_bits - 1) ss_n = 1'b1;
            sclk = 1'b1;
            check("miso_bit", 32'(miso), 32'(exp_word[i]));
            got = {got[30:0], miso};
            if (i == 0) miso_words.push_back(got);
            if (b < counted && i == 0) begin
                exp_rx.push_back(mosi_buf[w]);
                last_rx = mosi_buf[w];
            end
            repeat (HALF) @(negedge clk);
            if (b < n_bits - 1 || (trailing_fall && !simul_end)) begin
                sclk = 1'b0;
                if (i == 0) falls++;
            end
        end
        if (!simul_end) begin
            repeat (HALF) @(negedge clk);
            ss_n = 1'b1;
        end
        repeat (8) @(negedge clk);
        sclk = 1'b0;
        repeat (12) @(negedge clk);
        check("frame_start_cnt", 32'(cnt_fs - fs0), 32'd1);
        check("frame_end_cnt", 32'(cnt_fe - fe0), 32'd1);
        check("partial_cnt", 32'(cnt_pe - pe0), 32'(exp_partial));
        check("tx_req_cnt", 32'(cnt_tr - tr0), 32'(1 + falls));
        check("rx_wvld_cnt", 32'(cnt_wv - wv0), 32'(counted / 32));
        check("rx_pending", 32'(exp_rx.size()), 32'd0);
        check("word_cnt_hold", 32'(word_cnt), 32'(counted / 32));
        check("rx_wdata_hold", rx_wdata, last_rx);
        check("miso_idle", 32'({miso_oe, miso}), 32'd0);
        exp_rx.delete();
        last_tr_delta = cnt_tr - tr0;
        last_pe_delta = cnt_pe - pe0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_miso"}, 32'(miso), 32'd0);
        check({tag, "_miso_oe"}, 32'(miso_oe), 32'd0);
        check({tag, "_tx_req"}, 32'(tx_req), 32'd0);
        check({tag, "_rx_wvld"}, 32'(rx_wvld), 32'd0);
        check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        check({tag, "_frame_end"}, 32'(frame_end), 32'd0);
        check({tag, "_partial_err"}, 32'(partial_err), 32'd0);
        check({tag, "_rx_wdata"}, rx_wdata, 32'd0);
        check({tag, "_word_cnt"}, 32'(word_cnt), 32'd0);
        check({tag, "_dbg_bus0"}, dbg_bus0, 32'd0);
    endtask

    task automatic set_tx(input int offset, input logic [31:0] val);
        tx_vals[tx_idx + offset] = val;
        if (offset == 0) tx_rdata = val;
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) tx_vals[k] = $urandom();
        tx_rdata = tx_vals[0];
        rst  = 1'b1;
        ss_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // One word: A5A5_0F0F in, 1234_5678 out.
        mosi_buf[0] = 32'hA5A5_0F0F;
        set_tx(0, 32'h1234_5678);
        run_frame(32, 1'b1, 1'b0);
        check("one_word_miso", (miso_words.size() != 0) ? miso_words[0] : 32'hX, 32'h1234_5678);
        check("one_word_rx", rx_wdata, 32'hA5A5_0F0F);
        check("one_word_cnt", 32'(word_cnt), 32'd1);
        check("one_word_partial", 32'(last_pe_delta), 32'd0);

        // Three-word burst; ss_n rises with sclk still high, so there is no trailing reload.
        for (int k = 0; k < 3; k++) mosi_buf[k] = $urandom();
        set_tx(0, 32'd1);
        set_tx(1, 32'd2);
        set_tx(2, 32'd3);
        run_frame(96, 1'b0, 1'b0);
        check("burst_tx_req", 32'(last_tr_delta), 32'd3);
        check("burst_word_cnt", 32'(word_cnt), 32'd3);
        check("burst_nwords", 32'(miso_words.size()), 32'd3);
        for (int k = 0; k < 3 && k < miso_words.size(); k++) begin
            check("burst_miso_word", miso_words[k], 32'(k + 1));
        end

        // Deselect after 20 bits of word 2.
        mosi_buf[0] = 32'hDEAD_BEEF;
        mosi_buf[1] = $urandom();
        run_frame(52, 1'b1, 1'b0);
        check("partial_rx_held", rx_wdata, 32'hDEAD_BEEF);
        check("partial_pulse", 32'(last_pe_delta), 32'd1);

        // ss_n rise together with the 32nd rising edge.
        mosi_buf[0] = $urandom();
        run_frame(32, 1'b0, 1'b1);
        check("simul_word_cnt", 32'(word_cnt), 32'd0);
        check("simul_partial", 32'(last_pe_delta), 32'd1);

        // Reset mid-word with ss_n low. Later pulses must not be received.
        begin
            int wv0, fs0, fe0;
            ss_n = 1'b1;
            sclk = 1'b0;
            repeat (8) @(negedge clk);
            ss_n = 1'b0;
            repeat (8) @(negedge clk);
            for (int b = 0; b < 10; b++) begin
                mosi = 1'($urandom_range(0, 1));
                repeat (HALF) @(negedge clk);
                sclk = 1'b1;
                repeat (HALF) @(negedge clk);
                sclk = 1'b0;
            end
            rst = 1'b1;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            check_reset_values("midrst");
            last_rx = '0;
            wv0 = cnt_wv; fs0 = cnt_fs; fe0 = cnt_fe;
            for (int b = 0; b < 54; b++) begin
                mosi = 1'($urandom_range(0, 1));
                repeat (HALF) @(negedge clk);
                sclk = 1'b1;
                repeat (HALF) @(negedge clk);
                sclk = 1'b0;
            end
            ss_n = 1'b1;
            repeat (10) @(negedge clk);
            check("midrst_no_wvld", 32'(cnt_wv - wv0), 32'd0);
            check("midrst_no_start", 32'(cnt_fs - fs0), 32'd0);
            check("midrst_no_end", 32'(cnt_fe - fe0), 32'd0);
            check("midrst_idle", 32'({miso_oe, miso}), 32'd0);
        end
        for (int k = 0; k < 2; k++) mosi_buf[k] = $urandom();
        run_frame(64, 1'b1, 1'b0);
        check("after_rst_rx", rx_wdata, mosi_buf[1]);

        // Randomized frames.
        for (int f = 0; f < 12; f++) begin
            int nb;
            bit tf, se;
            for (int k = 0; k < 8; k++) mosi_buf[k] = $urandom();
            nb = $urandom_range(1, 160);
            if ($urandom_range(0, 1) == 1) nb = 32 * $urandom_range(1, 5);
            tf = 1'($urandom_range(0, 1));
            se = ($urandom_range(0, 3) == 0);
            run_frame(nb, tf, se);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
